obs_capture: RTL and testbench
==============================

# obs_capture

Response-side capture unit for the AES concolic harness: the counterpart of the stimulus program counter that plays keys into `top`. It samples the DUT's 128-bit `out` whenever the observation strobe `__obs` is high, stamps each sample with the cycle number, and queues it in a small first-word-fall-through FIFO. A bench or host drains the FIFO through a valid/ready port. A running MISR signature over all observed samples allows single-compare pass/fail checking.

## Interface
Parameters:
- DATA_W, 128, width of the observed DUT output.
- DEPTH, 8, number of FIFO entries; must be a power of two and at least 2.
- TAG_W, 32, width of the cycle counter and of each entry's tag.
- POLY, 128'h87, MISR feedback polynomial taps, DATA_W bits.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- out  in  DATA_W  DUT output word to observe.
- __obs  in  1  observation strobe; sample `out` on this edge when high.
- rd_ready  in  1  consumer accepts the head entry this cycle.
- rd_valid  out  1  FIFO is non-empty; head entry is presented.
- rd_data  out  DATA_W  head entry data word.
- rd_tag  out  TAG_W  head entry cycle tag.
- count  out  $clog2(DEPTH)+1  number of occupied entries.
- overflow  out  1  sticky flag; a sample was dropped because the FIFO was full.
- signature  out  DATA_W  current MISR value.
- cycle  out  TAG_W  free-running cycle counter.

## Operation
- Reset values:
  - cycle=0, count=0, rd_valid=0, overflow=0, signature=0.
  - Read and write pointers are 0.
  - rd_data and rd_tag are don't-care while rd_valid=0; storage is not cleared.
- Cycle counter:
  - cycle increments by 1 on every edge after reset.
  - It wraps from 2^TAG_W−1 to 0 with no flag.
- Push:
  - Condition: `__obs`=1 at an edge, and either count<DEPTH or a pop occurs on the same edge.
  - The entry {tag=cycle before increment, data=out} is written at the write pointer.
  - The write pointer advances modulo DEPTH.
- Pop:
  - Condition: rd_valid && rd_ready at an edge.
  - The read pointer advances modulo DEPTH.
  - rd_ready while empty is ignored.
- count is next_count = count + push − pop. Simultaneous push and pop leaves count unchanged, including when full.
- Drop:
  - Condition: `__obs`=1 with count==DEPTH and no pop on that edge.
  - FIFO contents are not modified.
  - overflow is set to 1 and holds until rst.
- MISR:
  - Updates on every edge with `__obs`=1, including dropped samples.
  - signature_next = {signature[DATA_W-2:0],1'b0} ^ (signature[DATA_W-1] ? POLY : 0) ^ out.
  - Holds when `__obs`=0.
- rd_valid = (count != 0). rd_data and rd_tag are combinational reads of the head entry (FWFT).
- Reset mid-operation: all pending entries are discarded, the sticky flag clears, and signature and cycle return to 0 immediately (asynchronous).

## Timing
- Capture-to-visible latency is 1 cycle. A push on edge N into an empty FIFO gives rd_valid=1 after edge N.
- Pop-to-next-head latency is 0. After a popping edge, the following entry is presented in the same cycle, and rd_valid drops if the FIFO became empty.
- Throughput: one push and one pop per cycle, sustained indefinitely at any occupancy.
- The tag of a sample equals the `cycle` output value visible in the cycle before the capturing edge.
- `__obs` and `out` are sampled only at the edge. The harness drives them #1 after the edge, so they are stable for the capture.
- No combinational path exists from `__obs` or `out` to any output. rd_ready affects only registered state.

## Test plan
- Reset and idle:
  - Stimulus: hold rst high for 5 time units, release, run 10 edges with `__obs`=0.
  - Required: cycle=10, count=0, rd_valid=0, overflow=0, signature=0.
- Single capture:
  - Stimulus: after reset, assert `__obs` for one edge with out=128'h0123456789abcdef_fedcba9876543210 while cycle=3.
  - Required: rd_valid=1 next cycle, rd_data equals that word, rd_tag=3, signature=out. One edge with rd_ready=1 then gives rd_valid=0 and count=0.
- Fill and overflow:
  - Stimulus: with rd_ready=0, push 9 consecutive words 1..9.
  - Required: count=8 and overflow=1. Draining returns data 1..8 in order with consecutive tags; word 9 is absent.
  - Required: signature equals the MISR fold of all 9 words.
- Full with simultaneous push and pop:
  - Stimulus: fill with 8 words, then one edge with `__obs`=1, out=128'hAA, rd_ready=1.
  - Required: count stays 8, overflow stays 0, and the last entry drained is 128'hAA.
- MISR feedback:
  - Stimulus: preload signature to bit DATA_W-1 set via a push of 128'h8000…0, then push out=0.
  - Required: signature=128'h87 after the second push.
- Asynchronous reset mid-stream:
  - Stimulus: with 5 entries queued and overflow=1, pulse rst between edges.
  - Required: count, rd_valid, overflow, signature and cycle are 0 before the next clock edge.

Source files
------------

// File: rtl/obs_capture.sv
// -----------------------------------------------------------------------------
// obs_capture
//
// Response-side capture unit. Whenever the observation strobe is high at a
// rising edge, the DUT output word is stamped with the current cycle number
// and queued in a small first-word-fall-through FIFO. A consumer drains the
// FIFO through a valid/ready port. A MISR folds every observed word, dropped
// ones included, into a running signature, so a whole run can be judged by a
// single compare.
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   out        DUT output word to observe (DATA_W)
//   __obs      observation strobe, sampled at the edge
//   rd_ready   consumer takes the head entry on this edge
//   rd_valid   FIFO non-empty, head entry is presented
//   rd_data    head entry data word (DATA_W)
//   rd_tag     head entry cycle tag (TAG_W)
//   count      number of occupied entries ($clog2(DEPTH)+1)
//   overflow   sticky, a sample was dropped because the FIFO was full
//   signature  current MISR value (DATA_W)
//   cycle      free-running cycle counter (TAG_W)
// -----------------------------------------------------------------------------
module obs_capture #(
    parameter int                DATA_W = 128,
    parameter int                DEPTH  = 8,
    parameter int                TAG_W  = 32,
    parameter logic [DATA_W-1:0] POLY   = 'h87
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        out,
    input  logic                     __obs,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [TAG_W-1:0]         rd_tag,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DATA_W-1:0]        signature,
    output logic [TAG_W-1:0]         cycle
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              overflow_reg;
    logic              overflow_next;
    logic [DATA_W-1:0] sig_reg;
    logic [DATA_W-1:0] sig_next;
    logic [TAG_W-1:0]  cycle_reg;
    logic [TAG_W-1:0]  cycle_next;

    // Entry storage. Never cleared: contents only matter while occupied.
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [TAG_W-1:0]  tag_mem  [DEPTH];

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic drop;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // rd_ready while empty does nothing.
    assign pop   = rd_ready && !empty;

    // A full FIFO still accepts a sample when the head leaves on the same
    // edge, so back-to-back push/pop sustains full throughput.
    assign push  = __obs && (!full || pop);
    assign drop  = __obs && full && !pop;

    // -------------------------------------------------------------------------
    // MISR next value: shift left, fold the outgoing MSB back through POLY,
    // then mix in the observed word. One generate slice per bit.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] misr_step;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_misr
            if (gi == 0) begin : g_lsb
                assign misr_step[gi] = (sig_reg[DATA_W-1] & POLY[gi]) ^ out[gi];
            end else begin : g_bit
                assign misr_step[gi] = sig_reg[gi-1]
                                     ^ (sig_reg[DATA_W-1] & POLY[gi])
                                     ^ out[gi];
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
        // natural wrap of the adder is the modulo-DEPTH advance.
        wr_ptr_next   = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
        rd_ptr_next   = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
        count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);
        overflow_next = overflow_reg | drop;
        // Dropped samples still enter the signature.
        sig_next      = __obs ? misr_step : sig_reg;
        // Wraps silently at 2^TAG_W-1.
        cycle_next    = cycle_reg + 1'b1;
    end

    // -------------------------------------------------------------------------
    // Control registers (asynchronous reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            sig_reg      <= '0;
            cycle_reg    <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
            sig_reg      <= sig_next;
            cycle_reg    <= cycle_next;
        end
    end

    // -------------------------------------------------------------------------
    // Entry write. The tag is the cycle value before this edge's increment,
    // i.e. the cycle output seen during the cycle preceding the capture.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_reg] <= out;
            tag_mem[wr_ptr_reg]  <= cycle_reg;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Head entry is read combinationally from the read pointer so it
    // falls through with zero latency; everything depends only on registers.
    // -------------------------------------------------------------------------
    assign rd_valid  = !empty;
    assign rd_data   = data_mem[rd_ptr_reg];
    assign rd_tag    = tag_mem[rd_ptr_reg];
    assign count     = count_reg;
    assign overflow  = overflow_reg;
    assign signature = sig_reg;
    assign cycle     = cycle_reg;

endmodule

// File: tb/tb_obs_capture.sv
module tb_obs_capture;

    localparam int DATA_W = 128;
    localparam int DEPTH  = 8;
    localparam int TAG_W  = 32;

    logic              clk = 1'b1;
    logic              rst;
    logic [DATA_W-1:0] out_w;
    logic              obs;
    logic              rd_ready;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [TAG_W-1:0]  rd_tag;
    logic [3:0]        count;
    logic              overflow;
    logic [DATA_W-1:0] signature;
    logic [TAG_W-1:0]  cycle;

    int checks = 0;
    int errors = 0;

    obs_capture #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .POLY  (128'h87)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out      (out_w),
        .__obs    (obs),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_tag   (rd_tag),
        .count    (count),
        .overflow (overflow),
        .signature(signature),
        .cycle    (cycle)
    );

    // Rising edges at 10, 20, 30, ...
    always #5 clk = ~clk;

    typedef struct {
        bit           do_rst;
        bit           obs;
        logic [127:0] data;
        bit           ready;
        bit           exp_valid;
        logic [127:0] exp_data;
        logic [31:0]  exp_tag;
        int           exp_count;
        bit           exp_ovf;
    } vec_t;

    vec_t vecs [34];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Called #1 after an edge (or between edges); leaves time at #1 after
    // the next edge so outputs can be sampled and new inputs driven.
    task automatic step(input bit o, input logic [127:0] d, input bit r);
        obs      = o;
        out_w    = d;
        rd_ready = r;
        @(posedge clk);
        #1;
        obs      = 1'b0;
        rd_ready = 1'b0;
        out_w    = '0;
    endtask

    // Reset pulse between edges.
    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int n;
        // ---------------- build vector table ----------------
        n = 0;
        // Fill and overflow: words 1..9 pushed with rd_ready=0 from cycle 0.
        for (int i = 0; i < 9; i++) begin
            vecs[n] = '{do_rst: (i == 0), obs: 1'b1, data: 128'(i + 1), ready: 1'b0,
                        exp_valid: 1'b1, exp_data: 128'd1, exp_tag: 32'd0,
                        exp_count: (i < 8) ? i + 1 : 8, exp_ovf: (i == 8)};
            n++;
        end
        // Drain: after pop j the head is word j+2, tag j+1.
        for (int j = 0; j < 8; j++) begin
            vecs[n] = '{do_rst: 1'b0, obs: 1'b0, data: 128'd0, ready: 1'b1,
                        exp_valid: (j < 7), exp_data: 128'(j + 2), exp_tag: 32'(j + 1),
                        exp_count: 7 - j, exp_ovf: 1'b1};
            n++;
        end
        // Full with simultaneous push/pop: words 0x11..0x18, then 0xAA.
        for (int i = 0; i < 8; i++) begin
            vecs[n] = '{do_rst: (i == 0), obs: 1'b1, data: 128'(8'h11 + i), ready: 1'b0,
                        exp_valid: 1'b1, exp_data: 128'h11, exp_tag: 32'd0,
                        exp_count: i + 1, exp_ovf: 1'b0};
            n++;
        end
        vecs[n] = '{do_rst: 1'b0, obs: 1'b1, data: 128'hAA, ready: 1'b1,
                    exp_valid: 1'b1, exp_data: 128'h12, exp_tag: 32'd1,
                    exp_count: 8, exp_ovf: 1'b0};
        n++;
        // Queue is now 0x12..0x18, 0xAA (tag 8). After pop k head is entry k.
        for (int k = 1; k <= 8; k++) begin
            vecs[n] = '{do_rst: 1'b0, obs: 1'b0, data: 128'd0, ready: 1'b1,
                        exp_valid: (k < 8),
                        exp_data: (k == 7) ? 128'hAA : 128'(8'h12 + k),
                        exp_tag: 32'(1 + k), exp_count: 8 - k, exp_ovf: 1'b0};
            n++;
        end

        // ---------------- reset and idle ----------------
        rst      = 1'b1;
        obs      = 1'b0;
        out_w    = '0;
        rd_ready = 1'b0;
        #5;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
        chk("idle_cycle", 128'(cycle), 128'd10);
        chk("idle_count", 128'(count), 128'd0);
        chk("idle_valid", 128'(rd_valid), 128'd0);
        chk("idle_overflow", 128'(overflow), 128'd0);
        chk("idle_signature", signature, 128'd0);

        // ---------------- single capture at cycle 3 ----------------
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
        step(1'b1, 128'h0123456789abcdef_fedcba9876543210, 1'b0);
        chk("single_valid", 128'(rd_valid), 128'd1);
        chk("single_data", rd_data, 128'h0123456789abcdef_fedcba9876543210);
        chk("single_tag", 128'(rd_tag), 128'd3);
        chk("single_sig", signature, 128'h0123456789abcdef_fedcba9876543210);
        step(1'b0, '0, 1'b1);
        chk("single_pop_valid", 128'(rd_valid), 128'd0);
        chk("single_pop_count", 128'(count), 128'd0);
        // rd_ready while empty must not disturb anything.
        step(1'b0, '0, 1'b1);
        chk("empty_pop_count", 128'(count), 128'd0);

        // ---------------- table-driven sequences ----------------
        for (int v = 0; v < n; v++) begin
            if (vecs[v].do_rst) pulse_reset();
            step(vecs[v].obs, vecs[v].data, vecs[v].ready);
            chk($sformatf("vec%0d_count", v), 128'(count), 128'(vecs[v].exp_count));
            chk($sformatf("vec%0d_valid", v), 128'(rd_valid), 128'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_overflow", v), 128'(overflow), 128'(vecs[v].exp_ovf));
            if (vecs[v].exp_valid) begin
                chk($sformatf("vec%0d_data", v), rd_data, vecs[v].exp_data);
                chk($sformatf("vec%0d_tag", v), 128'(rd_tag), 128'(vecs[v].exp_tag));
            end
            // MISR fold of words 1..9 (none ever reaches the MSB): 37.
            if (v == 8) chk("fill_signature", signature, 128'h25);
        end

        // ---------------- MISR feedback ----------------
        pulse_reset();
        step(1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
        chk("misr_preload", signature, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
        step(1'b1, 128'd0, 1'b0);
        chk("misr_feedback", signature, 128'h87);

        // ---------------- async reset mid-stream ----------------
        pulse_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 128'(i + 100), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk("pre_rst_count", 128'(count), 128'd5);
        chk("pre_rst_overflow", 128'(overflow), 128'd1);
        rst = 1'b1;
        #1;
        chk("arst_count", 128'(count), 128'd0);
        chk("arst_valid", 128'(rd_valid), 128'd0);
        chk("arst_overflow", 128'(overflow), 128'd0);
        chk("arst_signature", signature, 128'd0);
        chk("arst_cycle", 128'(cycle), 128'd0);
        rst = 1'b0;
        step(1'b0, '0, 1'b0);
        chk("post_rst_cycle", 128'(cycle), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
